// File: rtl/layer_2_maxpool.sv
// -----------------------------------------------------------------------------
// layer_2_maxpool
//
// 2x2, stride-2 max-pooling stage for one IEEE-754 binary32 feature map that
// arrives in raster order, one pixel per accepted beat. Emits one pooled
// pixel per 2x2 window, producing an IMG_SIZE/2 x IMG_SIZE/2 map.
//
// Datapath:
//   - even row : the maximum of each horizontal pixel pair is parked in a
//                half-row line buffer (one entry per window column)
//   - odd row  : the maximum of each horizontal pair is combined with the
//                parked value from the row above and registered out
//
// Parameters:
//   DATA_WIDTH  pixel width (binary32 layout assumed: sign at the MSB)
//   IMG_SIZE    input map width and height; must be even
//
// Ports:
//   Clk         clock, all state updates on the rising edge
//   Rst         asynchronous active-low reset
//   data_in     input pixel
//   valid_in    data_in valid; accepted every cycle it is high
//   data_out    pooled pixel, registered; holds its value between pulses
//   valid_out   one-cycle pulse per pooled pixel
//   frame_done  one-cycle pulse coincident with the last valid_out of a frame
//
// Build option:
//   LAYER2_POOL_RELU_EN  when defined, any pooled result with the sign bit set
//                        (including -0) is forced to +0 before registering.
// -----------------------------------------------------------------------------
module layer_2_maxpool #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 208
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int HALF = IMG_SIZE / 2;
  localparam int CW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(IMG_SIZE - 1);

  // ---------------------------------------------------------------------------
  // Floating-point maximum on raw bit patterns.
  //   - differing signs : the non-negative operand wins (+0 beats -0)
  //   - both positive   : larger magnitude field wins
  //   - both negative   : smaller magnitude field wins
  //   - bit-equal       : a wins
  // NaN and Inf get no special treatment; they order by their bit patterns.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] fmax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic                  sa;
    logic                  sb;
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    if (sa != sb) begin
      fmax = sa ? b : a;
    end else if (!sa) begin
      fmax = (mb > ma) ? b : a;
    end else begin
      fmax = (mb < ma) ? b : a;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] linebuf [HALF];

  // ---------------------------------------------------------------------------
  // Position decode
  // ---------------------------------------------------------------------------
  logic          col_odd;
  logic          row_odd;
  logic          last_col;
  logic          last_row;
  logic [AW-1:0] lb_addr;

  assign col_odd  = col[0];
  assign row_odd  = row[0];
  assign last_col = (col == LAST_IDX);
  assign last_row = (row == LAST_IDX);
  // Each window column owns one line-buffer entry.
  assign lb_addr  = AW'(col >> 1);

  // ---------------------------------------------------------------------------
  // Pooling datapath
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] quad_max;
  logic [DATA_WIDTH-1:0] pooled;

  // NOTE: every signal driven from always_comb receives a value on every path
  // (defaults first), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pair_max = fmax(hold, data_in);
    quad_max = fmax(linebuf[lb_addr], pair_max);
`ifdef LAYER2_POOL_RELU_EN
    pooled   = quad_max[DATA_WIDTH-1] ? '0 : quad_max;
`else
    pooled   = quad_max;
`endif
  end

  // ---------------------------------------------------------------------------
  // Counters, hold register and registered outputs.
  // Nothing advances without valid_in; gap cycles only drop the pulses.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        // Left pixel of every horizontal pair is parked for one beat.
        if (!col_odd) begin
          hold <= data_in;
        end

        // Bottom-right pixel closes a window.
        if (row_odd && col_odd) begin
          data_out   <= pooled;
          valid_out  <= 1'b1;
          frame_done <= last_row && last_col;
        end

        // Raster counters; frame wrap falls out of the row wrap.
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Half-row line buffer: written on even rows, read on odd rows, so one port
  // suffices and it may map to RAM.
  // ---------------------------------------------------------------------------
  // NOTE: the memory has no reset; each entry is written on an even row
  // before the following odd row reads it, so stale contents are never seen.
  always_ff @(posedge Clk) begin
    if (valid_in && !row_odd && col_odd) begin
      linebuf[lb_addr] <= pair_max;
    end
  end

endmodule

// File: doc/layer_2_maxpool.md
Name: layer_2_maxpool

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the layer-2 feature-map convolution/accumulation path.
- Consumes one IEEE-754 single-precision pixel per accepted beat, in raster order, for one feature map.
- Emits one pooled pixel per 2x2 window, giving an IMG_SIZE/2 x IMG_SIZE/2 map for layer 3.
- Uses one half-row line buffer, column/row counters and a registered output.

Parameters:
- DATA_WIDTH, 32: pixel width; IEEE-754 binary32.
- IMG_SIZE, 208: input map width and height in pixels. Must be even; an odd value is unsupported.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  input pixel.
- valid_in  input  1  data_in is valid; accepted every cycle it is high (no backpressure).
- data_out  output  DATA_WIDTH  pooled pixel, registered.
- valid_out  output  1  one-cycle pulse per pooled pixel.
- frame_done  output  1  one-cycle pulse coincident with the last valid_out of a frame.

Behaviour:
- Reset (Rst low, asynchronous): col=0, row=0, hold register=0, data_out=0, valid_out=0, frame_done=0. Line-buffer contents are not reset; every entry is written before it is read.
- Counters advance only on valid_in=1. Gaps in valid_in freeze all state. Outputs deassert valid_out/frame_done in gap cycles; data_out holds its last value.
- Column wrap: col runs 0..IMG_SIZE-1, then returns to 0 and row increments.
- Frame wrap: at row=IMG_SIZE-1, col=IMG_SIZE-1, both counters return to 0. The next accepted beat is pixel (0,0) of a new frame.
- fmax(a,b):
  - Signs differ: the operand with sign bit 0 wins, so +0 beats -0.
  - Both sign 0: the larger {exp,mant} wins.
  - Both sign 1: the smaller {exp,mant} wins.
  - Exact bit-equal tie: a wins.
  - NaN/Inf are not special-cased; bit-pattern rules apply.
- Even row, even col: hold <= data_in.
- Even row, odd col: linebuf[col>>1] <= fmax(hold, data_in).
- Odd row, even col: hold <= data_in.
- Odd row, odd col: data_out <= fmax(linebuf[col>>1], fmax(hold, data_in)); valid_out <= 1.
- Latency: data_out/valid_out are valid exactly 1 cycle after the cycle accepting the window's 4th (bottom-right) pixel.
- frame_done <= 1 in the same edge as valid_out when the 4th pixel is at (IMG_SIZE-1, IMG_SIZE-1).
- Outputs per frame: (IMG_SIZE/2)^2 valid_out pulses (10816 at default).
- Line buffer: IMG_SIZE/2 entries x DATA_WIDTH. It may be inferred RAM with 1 write or 1 read per cycle. The even-row write and the odd-row read never occur in the same cycle.
- Reset mid-frame: the partial frame is discarded and no valid_out is issued for it. After release, the first accepted beat is treated as pixel (0,0).
- Back-to-back frames with valid_in continuously high: no bubble is required or inserted.

Optional Feature:
- Macro: LAYER2_POOL_RELU_EN.
- Defined: after pooling, any result with sign bit 1 (including -0, 32'h80000000) is replaced by +0 (32'h00000000) before it is registered into data_out. Latency is unchanged.
- Undefined: data_out is the raw fmax result.

Test Plan:
- Basic pooling, IMG_SIZE=4:
  - Row0 = 3f800000, 40000000, 40400000, 40800000.
  - Row1 = 3f000000, 40a00000, bf800000, 00000000.
  - Required outputs: 40a00000 then 40800000, each one cycle after row1 col1 / col3 acceptance.
  - Rows2-3 all 3f800000 -> two outputs of 3f800000.
- Negative and zero windows:
  - Window bf800000, c0000000, c0400000, bf000000 -> bf000000; with LAYER2_POOL_RELU_EN -> 00000000.
  - Window of four 80000000 -> 80000000.
  - Window 80000000, 00000000, 80000000, 80000000 -> 00000000.
- Stall robustness: repeat the first scenario with valid_in randomly low 50% of cycles. Required: identical data_out sequence, 4 valid_out pulses, no valid_out during gaps.
- Frame wrap: two consecutive IMG_SIZE=4 frames, valid_in held high. Required: 8 valid_out pulses, frame_done only with the 4th and 8th, and second-frame values independent of the first.
- Reset mid-frame: drive Rst low during row1 col2 of a frame, release, then send a full frame. Required: no valid_out from the aborted frame; exactly 4 correct outputs for the new frame; all outputs 0 while in reset.
- Default size smoke test: IMG_SIZE=208 with pixel value = raster index converted to float. Required: 10816 outputs, each equal to the bottom-right pixel of its window, and frame_done once.
